predict_mac_pipe: RTL and testbench
===================================

# predict_mac_pipe

Pipelined, parametrised multiply-accumulate unit for the prediction datapath. It multiplies an unsigned or signed `din0` by a signed `din1` through a configurable register pipeline, accumulates products over a framed vector (`first`/`last`), and emits one rounded, saturated result per vector. It replaces bare combinational multipliers wherever a dot product feeds a layer output, under ready/valid flow control.

## Interface
- `DIN0_WIDTH`, default 31: width of `din0`.
- `DIN1_WIDTH`, default 16: width of `din1`, always signed.
- `DIN0_SIGNED`, default 0: 0 means `din0` is unsigned (zero-extended); 1 means signed.
- `NUM_STAGE`, default 3, range 1..4: number of product pipeline registers.
- `ACC_WIDTH`, default 48: signed accumulator width. Must be ≥ `DIN0_WIDTH + DIN1_WIDTH`.
- `SHIFT`, default 8, range 0..ACC_WIDTH-1: arithmetic right shift applied at output.
- `OUT_WIDTH`, default 16: signed result width.
- `ap_clk` in 1: sole clock, rising edge.
- `ap_rst_n` in 1: reset, asynchronous, active-low.
- `ce` in 1: clock enable. Low freezes every register.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid & in_ready`.
- `din0` in DIN0_WIDTH: multiplicand.
- `din1` in DIN1_WIDTH: multiplier.
- `first` in 1: beat starts a vector and clears the accumulator.
- `last` in 1: beat ends a vector and produces a result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `dout` out OUT_WIDTH: rounded, saturated result.
- `dout_sat` out 1: saturation occurred anywhere in this vector.

## Operation
- Product width is P = DIN0_WIDTH + DIN1_WIDTH, signed. When DIN0_SIGNED=0, `din0` is extended with a leading 0 before the signed multiply. The product is exact and never wraps.
- Pipeline advance: `adv = ce & (~out_valid | out_ready)`. `in_ready = adv`. When `adv` = 0, all stages, the accumulator, and the output register hold.
- Each product stage carries the sideband signals `vld`, `first`, and `last` alongside the data. Bubbles (`vld`=0) pass through and do not touch the accumulator.
- Accumulate stage, on a valid beat:
  - `base` = 0 if `first` is set or the previous beat was `last`; otherwise `base` = acc.
  - sum = base + product, computed at ACC_WIDTH+1 bits.
  - If sum overflows the ACC_WIDTH signed range, it clamps to the max or min value and the sticky `sat` is set. `sat` is cleared under the same conditions as `base`.
- Output stage, on a valid `last` beat, computed from the accumulated sum:
  - Round half-up: add 2^(SHIFT-1) when SHIFT > 0.
  - Shift arithmetically right by SHIFT.
  - Saturate to the OUT_WIDTH signed range.
  - Load `dout`. `dout_sat` = sticky `sat` OR output saturation. Set `out_valid` = 1. After the load, the accumulator returns to 0.
- `out_valid` clears on `out_ready & ce` unless a new result loads in the same cycle.
- A beat with both `first` and `last` set forms a single-term vector.
- A beat without `first` that follows `last` starts a new vector from 0.

## Timing
- Reset values: `out_valid` = 0, `dout` = 0, `dout_sat` = 0, `in_ready` = 0 while `ap_rst_n` is low. All stage valids, accumulator, and `sat` are 0.
- Latency: a `last` beat accepted at edge t gives `out_valid` high after edge t + NUM_STAGE + 1, provided there is no stall. Every cycle with `adv` = 0 adds one cycle.
- Throughput: one beat per cycle, with a result every vector. Back-to-back single-beat vectors give `out_valid` continuously high when `out_ready` = 1.
- Stall: while `out_valid & ~out_ready`, `dout` and `dout_sat` are stable and no beat enters.
- Reset mid-vector or mid-pipeline discards all partial state. The first beat accepted after release starts a fresh vector.
- `ce` = 0 overrides `out_ready`: a result is not consumed while `ce` is low.

## Structure
- Shared package/header `predict_pkg` holds:
  - the P and widths localparam derivations;
  - the function `sat_signed(value, width)`;
  - the function `round_shift(value, shift)`.
- Sub-module `predict_mul_pipe`: signedness-aware multiplier with NUM_STAGE registers, a sideband bus, and the `adv` enable. It is reusable by the other layers.
- Top-level `predict_mac_pipe` contains the accumulator, sticky saturation, output register, and handshake.

## Test plan
All scenarios use default parameters.
- **Single beat:** `first`=`last`=1, `din0`=1000, `din1`=-3 → `dout`=-12 (0xFFF4), `dout_sat`=0, `out_valid` high 4 cycles after acceptance.
- **Exact vector:** 4 beats with `din0`=256 and `din1`=1,2,3,4 → `dout`=10, `dout_sat`=0, one `out_valid` pulse only.
- **Output saturation:** `din0`=2^31-1, `din1`=-32768, single beat → `dout`=-32768, `dout_sat`=1. The next vector (`din0`=256, `din1`=1) gives `dout`=1 and `dout_sat`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles while results are pending → `dout` stays stable and `in_ready`=0. After release, all 3 queued vectors produce the correct values in order with no lost or duplicated beats.
- **Clock enable:** drop `ce` for 3 cycles mid-pipeline → latency becomes 7 cycles and results are unchanged.
- **Reset mid-vector:** assert `ap_rst_n` low after 2 of 4 beats → outputs are 0 immediately. Then a single beat with `din0`=512, `din1`=1 gives `dout`=2.

Source files
------------

// File: rtl/predict_pkg.sv
// rtl/predict_pkg.sv - shared widths, sideband type and rounding/saturation helpers for the prediction datapath
package predict_pkg;

  localparam int DIN0_WIDTH_DEF = 31;
  localparam int DIN1_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 48;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int SHIFT_DEF      = 8;
  localparam int NUM_STAGE_DEF  = 3;
  localparam int P_DEF          = DIN0_WIDTH_DEF + DIN1_WIDTH_DEF;

  // Helpers work on one wide signed type so any accumulator/output width fits.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic first;
    logic last;
  } sb_t;

  localparam int SB_W = $bits(sb_t);

  function automatic int prod_width(input int din0_w, input int din1_w);
    return din0_w + din1_w;
  endfunction

  function automatic wide_t sat_signed(input wide_t value, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic wide_t round_shift(input wide_t value, input int shift);
    wide_t v;
    v = value;
    if (shift > 0) v = v + (wide_t'(1) <<< (shift - 1));
    return v >>> shift;
  endfunction

endpackage

// File: rtl/predict_mul_pipe.sv
// rtl/predict_mul_pipe.sv - signedness-aware multiplier with NUM_STAGE registers and a sideband bus
module predict_mul_pipe
  import predict_pkg::*;
#(
  parameter int DIN0_WIDTH  = 31,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN0_SIGNED = 0,
  parameter int NUM_STAGE   = 3,
  parameter int SB_WIDTH    = 2
) (
  input  logic                                       ap_clk,
  input  logic                                       ap_rst_n,
  input  logic                                       adv,
  input  logic                                       in_vld,
  input  logic [SB_WIDTH-1:0]                        in_sb,
  input  logic [DIN0_WIDTH-1:0]                      din0,
  input  logic signed [DIN1_WIDTH-1:0]               din1,
  output logic                                       out_vld,
  output logic [SB_WIDTH-1:0]                        out_sb,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0]    dout
);

  localparam int P = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [DIN0_WIDTH:0] w_a;
  logic signed [P-1:0]        w_prod;

  // One extra din0 bit makes the unsigned case a plain signed multiply; P bits hold it exactly.
  assign w_a    = (DIN0_SIGNED != 0) ? {din0[DIN0_WIDTH-1], din0} : {1'b0, din0};
  assign w_prod = P'(w_a) * P'(din1);

  logic signed [P-1:0]   r_prod [NUM_STAGE];
  logic                  r_vld  [NUM_STAGE];
  logic [SB_WIDTH-1:0]   r_sb   [NUM_STAGE];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_prod[i] <= '0;
        r_vld[i]  <= 1'b0;
        r_sb[i]   <= '0;
      end
    end else if (adv) begin
      r_prod[0] <= w_prod;
      r_vld[0]  <= in_vld;
      r_sb[0]   <= in_sb;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_prod[i] <= r_prod[i-1];
        r_vld[i]  <= r_vld[i-1];
        r_sb[i]   <= r_sb[i-1];
      end
    end
  end

  assign dout    = r_prod[NUM_STAGE-1];
  assign out_vld = r_vld[NUM_STAGE-1];
  assign out_sb  = r_sb[NUM_STAGE-1];

endmodule

// File: rtl/predict_mac_pipe.sv
// rtl/predict_mac_pipe.sv - framed multiply-accumulate with sticky saturation, rounded output and ready/valid handshake
module predict_mac_pipe
  import predict_pkg::*;
#(
  parameter int DIN0_WIDTH  = 31,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN0_SIGNED = 0,
  parameter int NUM_STAGE   = 3,
  parameter int ACC_WIDTH   = 48,
  parameter int SHIFT       = 8,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIN0_WIDTH-1:0]        din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  dout,
  output logic                         dout_sat
);

  localparam int P = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic          w_adv;
  logic          w_accept;
  sb_t           w_sb_in;
  logic          w_mvld;
  logic [SB_W-1:0] w_msb_bits;
  sb_t           w_msb;
  logic signed [P-1:0] w_mprod;

  // A held result blocks the whole pipe; ce low overrides a ready consumer.
  assign w_adv    = ce & (~out_valid | out_ready);
  assign in_ready = w_adv & ap_rst_n;
  assign w_accept = in_valid & in_ready;
  assign w_sb_in  = '{first: first, last: last};

  predict_mul_pipe #(
    .DIN0_WIDTH  (DIN0_WIDTH),
    .DIN1_WIDTH  (DIN1_WIDTH),
    .DIN0_SIGNED (DIN0_SIGNED),
    .NUM_STAGE   (NUM_STAGE),
    .SB_WIDTH    (SB_W)
  ) u_mul (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .adv      (w_adv),
    .in_vld   (w_accept),
    .in_sb    (w_sb_in),
    .din0     (din0),
    .din1     (din1),
    .out_vld  (w_mvld),
    .out_sb   (w_msb_bits),
    .dout     (w_mprod)
  );

  assign w_msb = sb_t'(w_msb_bits);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_sat;
  logic                        r_acc_vld;
  logic                        r_acc_last;
  logic                        w_restart;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_acc_ovf;
  logic signed [ACC_WIDTH-1:0] w_acc_next;

  // A new vector begins on an explicit first or on any beat following a last.
  assign w_restart  = w_msb.first | r_acc_last;
  assign w_base     = w_restart ? '0 : r_acc;
  assign w_sum      = (ACC_WIDTH+1)'(w_base) + (ACC_WIDTH+1)'(w_mprod);
  assign w_acc_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_acc_next = !w_acc_ovf ? w_sum[ACC_WIDTH-1:0] :
                      (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_acc_vld  <= 1'b0;
      r_acc_last <= 1'b0;
    end else if (w_adv) begin
      r_acc_vld <= w_mvld;
      if (w_mvld) begin
        r_acc      <= w_acc_next;
        r_sat      <= (r_sat & ~w_restart) | w_acc_ovf;
        r_acc_last <= w_msb.last;
      end else if (r_acc_vld & r_acc_last) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end
    end
  end

  wide_t w_rounded;
  wide_t w_clamped;
  logic  w_load;

  assign w_rounded = round_shift(wide_t'(r_acc), SHIFT);
  assign w_clamped = sat_signed(w_rounded, OUT_WIDTH);
  assign w_load    = r_acc_vld & r_acc_last;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      dout_sat  <= 1'b0;
    end else if (w_adv) begin
      out_valid <= w_load;
      if (w_load) begin
        dout     <= w_clamped[OUT_WIDTH-1:0];
        dout_sat <= r_sat | (w_clamped != w_rounded);
      end
    end
  end

endmodule

// File: tb/tb_predict_mac_pipe.sv
// tb/tb_predict_mac_pipe.sv - directed bench for predict_mac_pipe with a reference vector model
module tb_predict_mac_pipe;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [30:0]        din0 = '0;
  logic signed [15:0] din1 = '0;
  logic               first = 1'b0;
  logic               last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] dout;
  logic               dout_sat;

  predict_mac_pipe dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .first     (first),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .dout_sat  (dout_sat)
  );

  always #5 ap_clk = ~ap_clk;

  localparam longint ACC_MAX = (64'sd1 <<< 47) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< 47);

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint t_acc = 0;
  longint lat;
  int     n_pop = 0;
  int     n0;
  longint l_dout = 0;
  longint l_sat = 0;

  typedef struct {
    longint d;
    bit     s;
  } res_t;
  res_t q[$];

  longint m_acc = 0;
  bit     m_sat = 1'b0;
  bit     m_prev_last = 1'b0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Vector-level reference: exact products, clamped 48-bit sum, round half-up, >>> 8, clamp to 16 bits.
  task automatic model_accept(input longint a, input longint b, input bit f, input bit l);
    longint s;
    longint r;
    bit     os;
    if (f || m_prev_last) begin
      m_acc = 0;
      m_sat = 1'b0;
    end
    s = m_acc + a * b;
    if (s > ACC_MAX) begin s = ACC_MAX; m_sat = 1'b1; end
    if (s < ACC_MIN) begin s = ACC_MIN; m_sat = 1'b1; end
    m_acc = s;
    m_prev_last = l;
    if (l) begin
      r  = (m_acc + 128) >>> 8;
      os = 1'b0;
      if (r > 32767)  begin r = 32767;  os = 1'b1; end
      if (r < -32768) begin r = -32768; os = 1'b1; end
      q.push_back('{r, m_sat | os});
    end
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      q.delete();
      m_acc = 0;
      m_sat = 1'b0;
      m_prev_last = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("dout", longint'(dout), q[0].d);
          chk("dout_sat", longint'(dout_sat), longint'(q[0].s));
          if (out_ready && ce) begin
            l_dout = longint'(dout);
            l_sat  = longint'(dout_sat);
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready)
        model_accept(longint'(din0), longint'(din1), first, last);
    end
  end

  task automatic beat(input longint a, input longint b, input bit f, input bit l);
    bit ok;
    din0 = a[30:0];
    din1 = b[15:0];
    first = f;
    last = l;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge ap_clk);
      ok = in_ready;
      @(posedge ap_clk);
      #1;
    end
    in_valid = 1'b0;
    first = 1'b0;
    last = 1'b0;
    t_acc = cyc;
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_ov(output longint l);
    l = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk);
      if (out_valid) begin
        l = cyc - t_acc;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge ap_clk);
    end
    chk("drain_queue_empty", longint'(q.size()), 0);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge ap_clk);
    #1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_dout", longint'(dout), 0);
    chk("reset_dout_sat", longint'(dout_sat), 0);
    chk("reset_in_ready", longint'(in_ready), 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // single beat: 1000 * -3 = -3000 -> -12
    n0 = n_pop;
    beat(1000, -3, 1, 1);
    wait_ov(lat);
    chk("single_latency", lat, 4);
    drain();
    chk("single_dout", l_dout, -12);
    chk("single_sat", l_sat, 0);
    chk("single_pulses", longint'(n_pop - n0), 1);

    // exact vector 256*(1+2+3+4) = 2560 -> 10
    n0 = n_pop;
    beat(256, 1, 1, 0);
    beat(256, 2, 0, 0);
    beat(256, 3, 0, 0);
    beat(256, 4, 0, 1);
    drain();
    chk("vector_dout", l_dout, 10);
    chk("vector_sat", l_sat, 0);
    chk("vector_pulses", longint'(n_pop - n0), 1);

    // no first after last: 256*2 + 256*2 = 1024 -> 4
    beat(256, 2, 0, 0);
    beat(256, 2, 0, 1);
    drain();
    chk("implicit_restart_dout", l_dout, 4);

    // output saturation, then a clean vector
    beat(64'h7FFF_FFFF, -32768, 1, 1);
    drain();
    chk("outsat_dout", l_dout, -32768);
    chk("outsat_sat", l_sat, 1);
    beat(256, 1, 1, 1);
    drain();
    chk("after_sat_dout", l_dout, 1);
    chk("after_sat_sat", l_sat, 0);

    // back-to-back single-beat vectors
    n0 = n_pop;
    for (int i = 0; i < 4; i++) beat(256, longint'(i) - 2, 1, 1);
    drain();
    chk("b2b_pulses", longint'(n_pop - n0), 4);
    chk("b2b_last_dout", l_dout, 1);

    // backpressure with three vectors in flight
    out_ready = 1'b0;
    n0 = n_pop;
    beat(256, 1, 1, 1);
    beat(256, 5, 1, 1);
    beat(1000, -3, 1, 1);
    wait_ov(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("stall_out_valid", longint'(out_valid), 1);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_dout", longint'(dout), 1);
    end
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("bp_pulses", longint'(n_pop - n0), 3);
    chk("bp_last_dout", l_dout, -12);

    // clock enable dropped for three edges mid-pipeline
    beat(256, 3, 1, 1);
    @(posedge ap_clk);
    #1;
    ce = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ce = 1'b1;
    wait_ov(lat);
    chk("ce_latency", lat, 7);
    drain();
    chk("ce_dout", l_dout, 3);

    // reset mid-vector
    beat(256, 1, 1, 0);
    beat(256, 2, 0, 0);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_dout", longint'(dout), 0);
    chk("midrst_dout_sat", longint'(dout_sat), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    n0 = n_pop;
    beat(512, 1, 0, 1);
    wait_ov(lat);
    chk("post_rst_latency", lat, 4);
    drain();
    chk("post_rst_dout", l_dout, 2);
    chk("post_rst_pulses", longint'(n_pop - n0), 1);

    repeat (3) @(posedge ap_clk);
    #1;
    chk("idle_out_valid", longint'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
